rom_loader_mt: RTL

- Parametrised successor to the single-word cartridge loader.
- Receives host boot words over a req/ack handshake and unpacks each word MSB-first into bytes.
- Writes the bytes into one of NUM_TGT byte memories (target 0 = cartridge SRAM, others = char RAM, etc.), counts them against a host-supplied size and keeps a running 8-bit checksum.
- After loading, drives a size-dependent bank-mapped play address and releases the console reset.

---
 rtl/rom_loader_mt_if.sv | 27 ++
 rtl/rom_loader_mt.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rom_loader_mt_if.sv
// rtl/rom_loader_mt_if.sv - host boot-word handshake and target memory write bus
interface rom_loader_mt_if #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 19,
  parameter int SIZE_W     = 16,
  parameter int NUM_TGT    = 2,
  parameter int TGT_W      = 1
);
  logic [8*WORD_BYTES-1:0] host_data;
  logic                    host_req;
  logic                    host_ack;
  logic [SIZE_W-1:0]       host_size;
  logic [TGT_W-1:0]        tgt_sel;
  logic [ADDR_W-1:0]       mem_addr;
  logic [7:0]              mem_data;
  logic [NUM_TGT-1:0]      mem_we;

  modport master (
    output host_data, host_req, host_size, tgt_sel,
    input  host_ack, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  host_data, host_req, host_size, tgt_sel,
    output host_ack, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/rom_loader_mt.sv
// rtl/rom_loader_mt.sv - unpacks host boot words MSB-first into byte writes, then maps console play address
module rom_loader_mt #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 19,
  parameter int SIZE_W     = 16,
  parameter int NUM_TGT    = 2,
  parameter int TGT_W      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             host_reset,
  rom_loader_mt_if.slave   bus,
  input  logic [11:0]      cart_addr,
  input  logic [1:0]       cart_bs,
  output logic             done,
  output logic [7:0]       csum,
  output logic             vp_rst_n
);
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, WR, GAP, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0]       load_addr_q, load_addr_d;
  logic [SIZE_W-1:0]       count_q, count_d;
  logic [7:0]              csum_q, csum_d;
  logic                    done_q, done_d;
  logic [1:0]              mode_q, mode_d;
  logic                    mode_set_q, mode_set_d;
  logic                    ack_q, ack_d;
  logic [7:0]              mem_data_q, mem_data_d;

  logic [TGT_W-1:0]        tgt_idx;
  logic [NUM_TGT-1:0]      tgt_onehot;
  logic [31:0]             size_ext;
  logic [1:0]              size_mode;
  logic [13:0]             play_addr;

  function automatic logic [7:0] byte_at(input logic [8*WORD_BYTES-1:0] w,
                                         input logic [IDX_W-1:0] i);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (i == IDX_W'(k)) b = w[8*(WORD_BYTES-1-k) +: 8];
    end
    return b;
  endfunction

  assign tgt_idx    = bus.tgt_sel;
  assign tgt_onehot = NUM_TGT'(1) << tgt_idx;
  assign size_ext   = 32'(bus.host_size);

  always_comb begin
    size_mode = 2'd3;
    if      (size_ext < 32'h1000) size_mode = 2'd0;
    else if (size_ext < 32'h2000) size_mode = 2'd1;
    else if (size_ext < 32'h4000) size_mode = 2'd2;
  end

  always_comb begin
    play_addr = '0;
    case (mode_q)
      2'd0:    play_addr = {3'b000, cart_addr[11], cart_addr[9:0]};
      2'd1:    play_addr = {2'b00, cart_bs[0], cart_addr[11], cart_addr[9:0]};
      2'd2:    play_addr = {1'b0, cart_bs[1], cart_bs[0], cart_addr[11], cart_addr[9:0]};
      default: play_addr = {cart_bs[1], cart_bs[0], cart_addr[11:0]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    load_addr_d = load_addr_q;
    count_d     = count_q;
    csum_d      = csum_q;
    done_d      = done_q;
    mode_d      = mode_q;
    mode_set_d  = mode_set_q;
    ack_d       = 1'b0;
    mem_data_d  = mem_data_q;

    if (host_reset) begin
      state_d     = IDLE;
      word_d      = '0;
      idx_d       = '0;
      load_addr_d = '0;
      count_d     = '0;
      csum_d      = '0;
      done_d      = 1'b0;
      mode_d      = '0;
      mode_set_d  = 1'b0;
      mem_data_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.host_req) begin
            word_d     = bus.host_data;
            ack_d      = 1'b1;
            idx_d      = '0;
            mem_data_d = bus.host_data[8*WORD_BYTES-1 -: 8];
            state_d    = WR;
            // Mode comes only from the first word of a cartridge (target 0) session.
            if (!mode_set_q) begin
              mode_set_d = 1'b1;
              if (tgt_idx == '0) mode_d = size_mode;
            end
          end else if (count_q >= bus.host_size) begin
            done_d = 1'b1;
          end
        end
        WR: state_d = GAP;
        GAP: begin
          if (!done_q) begin
            load_addr_d = load_addr_q + 1'b1;
            count_d     = count_q + 1'b1;
            csum_d      = csum_q + mem_data_q;
            if (count_d >= bus.host_size) done_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = HOLD;
          end else begin
            idx_d      = idx_q + 1'b1;
            mem_data_d = byte_at(word_q, idx_d);
            state_d    = WR;
          end
        end
        default: begin
          // A level-held request must fall before the next word can be taken.
          if (!bus.host_req) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      load_addr_q <= '0;
      count_q     <= '0;
      csum_q      <= '0;
      done_q      <= 1'b0;
      mode_q      <= '0;
      mode_set_q  <= 1'b0;
      ack_q       <= 1'b0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      load_addr_q <= load_addr_d;
      count_q     <= count_d;
      csum_q      <= csum_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      mode_set_q  <= mode_set_d;
      ack_q       <= ack_d;
      mem_data_q  <= mem_data_d;
    end
  end

  // host_reset kills an in-flight strobe in the same cycle it is raised.
  assign bus.mem_we   = (state_q == WR && !done_q && !host_reset) ? tgt_onehot : '0;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_addr = done_q ? ADDR_W'(play_addr) : load_addr_q;
  assign bus.host_ack = ack_q;
  assign done         = done_q;
  assign csum         = csum_q;
  assign vp_rst_n     = done_q;
endmodule
